// File: rtl/ir_cmd_arbiter.sv
// Round-robin merge of IR and keyboard command codes into a FWFT queue,
// with null filtering and per-source repeat hold-off. Option: IR_CMD_DROP_COUNT_EN.
module ir_cmd_arbiter #(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 1000,
    parameter int CODE_W      = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ir_valid,
    input  logic [CODE_W-1:0]          ir_code,
    output logic                       ir_ready,
    input  logic                       kb_valid,
    input  logic [CODE_W-1:0]          kb_code,
    output logic                       kb_ready,
    output logic                       cmd_valid,
    output logic [CODE_W-1:0]          cmd_code,
    output logic                       cmd_src,
    input  logic                       cmd_ready,
`ifdef IR_CMD_DROP_COUNT_EN
    output logic [7:0]                 drop_cnt,
`endif
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int TW = $clog2(HOLD_CYCLES+1);

    typedef enum logic [1:0] {
        IDLE,
        GRANT_IR,
        GRANT_KB,
        BLOCKED
    } arb_t;

    arb_t                arb;
    logic                prio;
    logic                full;
    logic                accept;
    logic                sel;
    logic [CODE_W-1:0]   acc_code;
    logic                is_null;
    logic                repeat_hit;
    logic                push;
    logic                pop;
    logic [CW-1:0]       count;
    logic [AW-1:0]       wptr;
    logic [AW-1:0]       rptr;
    logic [CODE_W:0]     mem [DEPTH];
    logic [CODE_W:0]     head;
    logic [CODE_W-1:0]   last_code [2];
    logic [TW-1:0]       hold [2];

    assign full = (count == CW'(DEPTH));

    // prio = 0 favours IR on a contested cycle
    always_comb begin
        arb = IDLE;
        if (full)
            arb = BLOCKED;
        else if (ir_valid && (!kb_valid || !prio))
            arb = GRANT_IR;
        else if (kb_valid)
            arb = GRANT_KB;
    end

    assign ir_ready   = (arb == GRANT_IR);
    assign kb_ready   = (arb == GRANT_KB);
    assign accept     = ir_ready || kb_ready;
    assign sel        = (arb == GRANT_KB);
    assign acc_code   = sel ? kb_code : ir_code;
    assign is_null    = (acc_code == '0);
    assign repeat_hit = accept && !is_null &&
                        (hold[sel] != '0) &&
                        (last_code[sel] == acc_code);
    assign push       = accept && !is_null && !repeat_hit;
    assign pop        = cmd_ready && (count != '0);

    assign head       = mem[rptr];
    assign cmd_valid  = (count != '0);
    assign cmd_code   = cmd_valid ? head[CODE_W-1:0] : '0;
    assign cmd_src    = cmd_valid ? head[CODE_W] : 1'b0;
    assign fifo_count = count;

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= {sel, acc_code};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            wptr  <= '0;
            rptr  <= '0;
            prio  <= 1'b0;
            for (int s = 0; s < 2; s++) begin
                last_code[s] <= '0;
                hold[s]      <= '0;
            end
        end else begin
            if (ir_valid && kb_valid && !full)
                prio <= ~prio;
            // suppressed repeats reload too, so a held button stays quiet
            for (int s = 0; s < 2; s++) begin
                if (accept && !is_null && (sel == s[0])) begin
                    hold[s]      <= TW'(HOLD_CYCLES);
                    last_code[s] <= acc_code;
                end else if (hold[s] != '0) begin
                    hold[s] <= hold[s] - TW'(1);
                end
            end
            if (push)
                wptr <= wptr + AW'(1);
            if (pop)
                rptr <= rptr + AW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
        end
    end

`ifdef IR_CMD_DROP_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            drop_cnt <= '0;
        else if (repeat_hit && (drop_cnt != 8'hFF))
            drop_cnt <= drop_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_ir_cmd_arbiter.sv
// Directed vector table plus hand sequences for ir_cmd_arbiter
// (DEPTH=4, HOLD_CYCLES=10).
module tb_ir_cmd_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       ir_valid, kb_valid, cmd_ready;
    logic [7:0] ir_code, kb_code;
    logic       ir_ready, kb_ready, cmd_valid, cmd_src;
    logic [7:0] cmd_code;
    logic [2:0] fifo_count;
`ifdef IR_CMD_DROP_COUNT_EN
    logic [7:0] drop_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ir_cmd_arbiter #(
        .DEPTH(4),
        .HOLD_CYCLES(10),
        .CODE_W(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ir_valid(ir_valid),
        .ir_code(ir_code),
        .ir_ready(ir_ready),
        .kb_valid(kb_valid),
        .kb_code(kb_code),
        .kb_ready(kb_ready),
        .cmd_valid(cmd_valid),
        .cmd_code(cmd_code),
        .cmd_src(cmd_src),
        .cmd_ready(cmd_ready),
`ifdef IR_CMD_DROP_COUNT_EN
        .drop_cnt(drop_cnt),
`endif
        .fifo_count(fifo_count)
    );

    typedef struct {
        logic       iv;
        logic [7:0] ic;
        logic       kv;
        logic [7:0] kc;
        logic       cr;
        logic       eir;
        logic       ekb;
        logic       ecv;
        logic [7:0] ecode;
        logic       esrc;
        logic [2:0] ecnt;
    } vec_t;

    vec_t tbl [25];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [7:0] ic,
                         input logic kv, input logic [7:0] kc,
                         input logic cr);
        ir_valid  = iv;
        ir_code   = ic;
        kb_valid  = kv;
        kb_code   = kc;
        cmd_ready = cr;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 8'h00, 0, 8'h00, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // one clocked cycle with the given inputs, starting at a negedge
    task automatic cyc(input logic iv, input logic [7:0] ic,
                       input logic kv, input logic [7:0] kc,
                       input logic cr);
        drive(iv, ic, kv, kc, cr);
        @(negedge clk);
    endtask

    initial begin
        //             iv ic     kv kc     cr eir ekb ecv code   src cnt
        tbl[0]  = '{0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 3'd0};
        tbl[1]  = '{1, 8'h05, 0, 8'h00, 1, 1, 0, 0, 8'h00, 0, 3'd0};
        tbl[2]  = '{0, 8'h00, 0, 8'h00, 1, 0, 0, 1, 8'h05, 0, 3'd1};
        tbl[3]  = '{0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 3'd0};
        tbl[4]  = '{1, 8'h01, 1, 8'h09, 1, 1, 0, 0, 8'h00, 0, 3'd0};
        tbl[5]  = '{1, 8'h02, 1, 8'h09, 1, 0, 1, 1, 8'h01, 0, 3'd1};
        tbl[6]  = '{1, 8'h02, 1, 8'h0A, 1, 1, 0, 1, 8'h09, 1, 3'd1};
        tbl[7]  = '{1, 8'h01, 1, 8'h0A, 1, 0, 1, 1, 8'h02, 0, 3'd1};
        tbl[8]  = '{0, 8'h00, 0, 8'h00, 1, 0, 0, 1, 8'h0A, 1, 3'd1};
        tbl[9]  = '{0, 8'h00, 1, 8'h01, 0, 0, 1, 0, 8'h00, 0, 3'd0};
        tbl[10] = '{0, 8'h00, 1, 8'h02, 0, 0, 1, 1, 8'h01, 1, 3'd1};
        tbl[11] = '{0, 8'h00, 1, 8'h06, 0, 0, 1, 1, 8'h01, 1, 3'd2};
        tbl[12] = '{0, 8'h00, 1, 8'h08, 0, 0, 1, 1, 8'h01, 1, 3'd3};
        tbl[13] = '{0, 8'h00, 1, 8'h05, 0, 0, 0, 1, 8'h01, 1, 3'd4};
        tbl[14] = '{0, 8'h00, 1, 8'h05, 1, 0, 0, 1, 8'h01, 1, 3'd4};
        tbl[15] = '{0, 8'h00, 1, 8'h05, 0, 0, 1, 1, 8'h02, 1, 3'd3};
        tbl[16] = '{1, 8'h03, 1, 8'h07, 0, 0, 0, 1, 8'h02, 1, 3'd4};
        tbl[17] = '{0, 8'h00, 0, 8'h00, 1, 0, 0, 1, 8'h02, 1, 3'd4};
        tbl[18] = '{0, 8'h00, 0, 8'h00, 1, 0, 0, 1, 8'h06, 1, 3'd3};
        tbl[19] = '{0, 8'h00, 0, 8'h00, 1, 0, 0, 1, 8'h08, 1, 3'd2};
        tbl[20] = '{0, 8'h00, 0, 8'h00, 1, 0, 0, 1, 8'h05, 1, 3'd1};
        tbl[21] = '{1, 8'h00, 0, 8'h00, 1, 1, 0, 0, 8'h00, 0, 3'd0};
        tbl[22] = '{1, 8'h00, 0, 8'h00, 1, 1, 0, 0, 8'h00, 0, 3'd0};
        tbl[23] = '{1, 8'h00, 0, 8'h00, 1, 1, 0, 0, 8'h00, 0, 3'd0};
        tbl[24] = '{0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 3'd0};

        do_reset();
        chk("rst_code", {24'd0, cmd_code}, 32'h0);
        chk("rst_src", {31'd0, cmd_src}, 32'h0);
`ifdef IR_CMD_DROP_COUNT_EN
        chk("rst_drop", {24'd0, drop_cnt}, 32'h0);
`endif

        for (int i = 0; i < 25; i++) begin
            drive(tbl[i].iv, tbl[i].ic, tbl[i].kv, tbl[i].kc, tbl[i].cr);
            #1;
            chk($sformatf("v%0d_ir_ready", i), {31'd0, ir_ready},
                {31'd0, tbl[i].eir});
            chk($sformatf("v%0d_kb_ready", i), {31'd0, kb_ready},
                {31'd0, tbl[i].ekb});
            chk($sformatf("v%0d_cmd_valid", i), {31'd0, cmd_valid},
                {31'd0, tbl[i].ecv});
            chk($sformatf("v%0d_count", i), {29'd0, fifo_count},
                {29'd0, tbl[i].ecnt});
            if (tbl[i].ecv) begin
                chk($sformatf("v%0d_code", i), {24'd0, cmd_code},
                    {24'd0, tbl[i].ecode});
                chk($sformatf("v%0d_src", i), {31'd0, cmd_src},
                    {31'd0, tbl[i].esrc});
            end
            @(negedge clk);
        end

        // repeat suppression window, HOLD_CYCLES = 10
        do_reset();
        cyc(1, 8'h07, 0, 8'h00, 0);
        repeat (4) cyc(0, 8'h00, 0, 8'h00, 0);
        drive(1, 8'h07, 0, 8'h00, 0);
        #1;
        chk("rep_ready", {31'd0, ir_ready}, 32'h1);
        @(negedge clk);
        chk("rep_suppressed_cnt", {29'd0, fifo_count}, 32'd1);
        repeat (14) cyc(0, 8'h00, 0, 8'h00, 0);
        cyc(1, 8'h07, 0, 8'h00, 0);
        chk("rep_expired_cnt", {29'd0, fifo_count}, 32'd2);
`ifdef IR_CMD_DROP_COUNT_EN
        chk("rep_drop_cnt", {24'd0, drop_cnt}, 32'd1);
`endif
        // IR hold-off still running; keyboard 0x07 must pass
        cyc(0, 8'h00, 1, 8'h07, 0);
        chk("indep_cnt", {29'd0, fifo_count}, 32'd3);
        drive(0, 8'h00, 0, 8'h00, 0);

        // asynchronous reset with three entries queued
        #3;
        reset = 1'b1;
        #1;
        chk("arst_valid", {31'd0, cmd_valid}, 32'h0);
        chk("arst_cnt", {29'd0, fifo_count}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        cyc(0, 8'h00, 1, 8'h0A, 0);
        drive(0, 8'h00, 0, 8'h00, 0);
        #1;
        chk("post_rst_valid", {31'd0, cmd_valid}, 32'h1);
        chk("post_rst_code", {24'd0, cmd_code}, 32'h0A);
        chk("post_rst_src", {31'd0, cmd_src}, 32'h1);
        chk("post_rst_cnt", {29'd0, fifo_count}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/ir_cmd_arbiter.md
Name: ir_cmd_arbiter

Overview:
- Sits between the IR code decoder and the downstream command mux.
- Merges two 8-bit command requesters into one buffered, handshaked command stream:
  - source 0: decoded IR remote codes
  - source 1: keyboard/pad codes
- Handles fair arbitration, repeat suppression and null-code filtering, so the mux consumer sees each button press once, in order.

Parameters:
- DEPTH, 4: command FIFO entries; power of 2, minimum 2.
- HOLD_CYCLES, 1000: repeat-suppression window in clk cycles, per source; minimum 1.
- CODE_W, 8: command code width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- ir_valid  in  1  IR requester has a code.
- ir_code  in  CODE_W  IR command code.
- ir_ready  out  1  IR code accepted this cycle when ir_valid is also high.
- kb_valid  in  1  keyboard requester has a code.
- kb_code  in  CODE_W  keyboard command code.
- kb_ready  out  1  keyboard code accepted this cycle when kb_valid is also high.
- cmd_valid  out  1  FIFO head valid.
- cmd_code  out  CODE_W  FIFO head code.
- cmd_src  out  1  FIFO head source: 0 = IR, 1 = keyboard.
- cmd_ready  in  1  consumer pops the head when cmd_valid is also high.
- fifo_count  out  $clog2(DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset (async assert, sync release to clk):
  - FIFO empty; cmd_valid = 0, cmd_code = 0, cmd_src = 0, fifo_count = 0.
  - Priority pointer = IR.
  - Both last_code registers = 0; both hold timers = 0.
  - Reset mid-operation discards all queued commands immediately.
- Handshake rules:
  - Valid/ready on every interface. A transfer happens on a clk edge where valid && ready.
  - A requester holds its code stable while valid && !ready.
- Arbitration:
  - At most one requester accepted per cycle.
  - "full" means fifo_count == DEPTH, from the registered count. A pop in the same cycle does not free space for a push.
  - If full: ir_ready = 0 and kb_ready = 0.
  - If not full and only one requester is valid: that requester's ready = 1.
  - If not full and both are valid: the requester named by the priority pointer wins and the other sees ready = 0.
  - The pointer toggles to the loser after every contested grant; uncontested grants leave it unchanged (round-robin).
  - ready may be combinational from the valid inputs and the registered state.
- Accept filtering: an accepted code is enqueued unless either condition below holds. Filtered codes are still handshaken (ready = 1) but not stored.
  - (a) code == 0: the null/"no change" code.
  - (b) Repeat: code == that source's last_code and that source's hold timer != 0.
- Per-source repeat timer:
  - Every accept of a nonzero code loads that source's timer with HOLD_CYCLES and sets last_code to the code. This applies to suppressed repeats too, so a held button stays suppressed.
  - Otherwise the timer decrements by 1 per cycle and saturates at 0.
  - Code 0 does not touch the timer or last_code.
  - Timers are independent: an IR repeat never suppresses a keyboard code.
- FIFO:
  - First-word fall-through. cmd_valid = (fifo_count != 0); cmd_code and cmd_src show the head entry {src, code}.
  - Push and pop in the same cycle when 0 < count < DEPTH: count unchanged, order preserved.
  - Pop when empty is ignored.
  - Read/write pointers wrap modulo DEPTH.
- Latency: a code accepted at edge N shows on cmd_* after edge N with cmd_valid = 1, provided the FIFO was empty.
- Internal per-cycle arbitration states:
  - IDLE: no valid requester.
  - GRANT_IR.
  - GRANT_KB.
  - BLOCKED: full.
  These are decoded from registered state; there is no multi-cycle transaction.

Optional Feature:
- Macro: IR_CMD_DROP_COUNT_EN.
- When defined:
  - Adds output port drop_cnt (8 bits).
  - drop_cnt is a saturating count of codes suppressed by the repeat rule, both sources combined. Null codes are not counted.
  - Saturates at 255; reset value 0.
- When undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then ir_valid = 1, ir_code = 0x05 for one cycle, cmd_ready = 1 -> next cycle cmd_valid = 1, cmd_code = 0x05, cmd_src = 0; popped; fifo_count returns to 0.
- HOLD_CYCLES = 10: IR 0x07 accepted, then IR 0x07 again 5 cycles later -> second not enqueued, fifo_count stays 1. Then IR 0x07 15 cycles after that -> enqueued, fifo_count = 2 (timer restarted at the second accept). With the macro defined, drop_cnt = 1.
- IR and keyboard both valid every cycle (IR cycles 0x01/0x02, keyboard cycles 0x09/0x0A), cmd_ready = 1 -> grants alternate IR, KB, IR, KB starting with IR; cmd_src sequence is 0,1,0,1.
- cmd_ready = 0, keyboard pushes 0x01, 0x02, 0x06, 0x08 -> fifo_count = 4, kb_ready = 0 on the 5th code. Then cmd_ready = 1 for one cycle -> 0x01 popped, and kb_ready = 1 the following cycle.
- ir_code = 0x00 valid for 3 cycles -> ir_ready = 1 each cycle, fifo_count stays 0, cmd_valid stays 0.
- FIFO holding 3 entries, assert reset mid-cycle (asynchronously) -> cmd_valid = 0 and fifo_count = 0 immediately. After release, keyboard 0x0A is accepted and appears as the head entry.
